rx_drain_ctrl: RTL

RX_DRAIN_CTRL -- requirements
Module: rx_drain_ctrl

---
 rtl/rx_drain_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rx_drain_ctrl.sv
// Purpose: drains frames word by word from a MAC receive buffer to a valid/ready sink, with drop, truncation and missing-start recovery.
// Latency: out_valid rises 3 edges after the IDLE start condition and 3 edges after each accepted word; one MAC pop per word.
// Backpressure: a presented word is held until out_ready or drop_req; no pop is issued while a word is presented.
module rx_drain_ctrl #(
  parameter int MAX_WORDS = 380,
  parameter int CNT_W     = 16
) (
  input  logic             data_out_clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [6:0]       mac_frame_count,
  input  logic [31:0]      mac_data,
  input  logic             mac_start,
  input  logic             mac_end,
  output logic             mac_enable,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_start,
  output logic             out_end,
  output logic             out_error,
  input  logic             drop_req,
  output logic             busy,
  output logic [CNT_W-1:0] frames_forwarded,
  output logic [CNT_W-1:0] frames_dropped
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    CAP       = 3'd2,
    PRESENT   = 3'd3,
    FLUSH_POP = 3'd4,
    FLUSH_CAP = 3'd5
  } state_t;

  localparam logic [8:0]       MAX_W   = 9'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state, state_nxt;
  logic [8:0] word_cnt;
  logic [8:0] word_cnt_inc;
  logic       first_word;
  logic       held_end;

  logic       start_frame;
  logic       capture;
  logic       bad_start;
  logic       trunc_now;
  logic       release_word;
  logic       inc_fwd;
  logic       inc_drop;

  assign word_cnt_inc = word_cnt + 9'd1;
  // A held word is a genuine MAC end only if it was not forced to end by truncation.
  assign held_end     = out_end & ~out_error;
  assign busy         = (state != IDLE);

  // State register.
  always_ff @(posedge data_out_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_nxt    = state;
    start_frame  = 1'b0;
    capture      = 1'b0;
    bad_start    = 1'b0;
    trunc_now    = 1'b0;
    release_word = 1'b0;
    inc_fwd      = 1'b0;
    inc_drop     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (mac_frame_count != 7'd0)) begin
          state_nxt   = POP;
          start_frame = 1'b1;
        end
      end
      POP: state_nxt = CAP;
      CAP: begin
        capture = 1'b1;
        if (first_word && !mac_start) begin
          // Frame without a start marker (e.g. tail after a reset): discard it.
          bad_start = 1'b1;
          inc_drop  = 1'b1;
          state_nxt = mac_end ? FLUSH_CAP : FLUSH_POP;
        end else begin
          state_nxt = PRESENT;
          trunc_now = (word_cnt_inc == MAX_W) && !mac_end;
        end
      end
      PRESENT: begin
        if (drop_req) begin
          release_word = 1'b1;
          inc_drop     = 1'b1;
          state_nxt    = held_end ? IDLE : FLUSH_POP;
        end else if (out_ready) begin
          release_word = 1'b1;
          if (out_error) begin
            inc_drop  = 1'b1;
            state_nxt = FLUSH_POP;
          end else if (out_end) begin
            inc_fwd   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = POP;
          end
        end
      end
      FLUSH_POP: state_nxt = FLUSH_CAP;
      FLUSH_CAP: state_nxt = mac_end ? IDLE : FLUSH_POP;
      default:   state_nxt = IDLE;
    endcase
  end

  // Pop request is registered so it is high exactly while in POP or FLUSH_POP.
  always_ff @(posedge data_out_clock or posedge reset) begin
    if (reset) mac_enable <= 1'b0;
    else       mac_enable <= (state_nxt == POP) || (state_nxt == FLUSH_POP);
  end

  // Word counter, first-word flag and the presented output word.
  always_ff @(posedge data_out_clock or posedge reset) begin
    if (reset) begin
      word_cnt   <= 9'd0;
      first_word <= 1'b0;
      out_data   <= 32'd0;
      out_valid  <= 1'b0;
      out_start  <= 1'b0;
      out_end    <= 1'b0;
      out_error  <= 1'b0;
    end else begin
      if (start_frame) begin
        word_cnt   <= 9'd0;
        first_word <= 1'b1;
      end
      if (capture) begin
        word_cnt   <= word_cnt_inc;
        first_word <= 1'b0;
        out_data   <= mac_data;
        out_start  <= first_word & mac_start;
        out_end    <= mac_end | trunc_now;
        out_error  <= trunc_now;
        out_valid  <= ~bad_start;
      end
      if (release_word) out_valid <= 1'b0;
    end
  end

  // Saturating frame statistics.
  always_ff @(posedge data_out_clock or posedge reset) begin
    if (reset) begin
      frames_forwarded <= '0;
      frames_dropped   <= '0;
    end else begin
      if (inc_fwd && (frames_forwarded != CNT_MAX))
        frames_forwarded <= frames_forwarded + CNT_ONE;
      if (inc_drop && (frames_dropped != CNT_MAX))
        frames_dropped <= frames_dropped + CNT_ONE;
    end
  end

endmodule
